// File: rtl/link_pkg.sv
// Shared constants and state encoding for the inter-node serial link.
// Used by both the receiver and the master side of the link.
package link_pkg;

    localparam int DEFAULT_WORD_W      = 32;
    localparam int DEFAULT_SYNC_STAGES = 2;

    // Link-wide framing constants the master side relies on as well.
    localparam bit LINK_MSB_FIRST      = 1'b1;
    localparam int MIN_CLK_SCLK_RATIO  = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        WAIT_CS = 2'd2
    } link_state_e;

endpackage

// File: rtl/spi_link_receiver_if.sv
// Bundle of link pins and receiver-queue handshake for one inbound port.
// The master modport is the driving side, the slave modport is the receiver.
interface spi_link_receiver_if #(
    parameter int WORD_W = link_pkg::DEFAULT_WORD_W
);

    logic              sclk_in;
    logic              cs_in;
    logic              sdi_in;
    logic              word_ack;
    logic              clear_err;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              overrun_err;
    logic              frame_err;
    logic              busy;

    modport master (
        output sclk_in, cs_in, sdi_in, word_ack, clear_err,
        input  word_out, word_valid, overrun_err, frame_err, busy
    );

    modport slave (
        input  sclk_in, cs_in, sdi_in, word_ack, clear_err,
        output word_out, word_valid, overrun_err, frame_err, busy
    );

endinterface

// File: rtl/sync_edge_detect.sv
// Multi-stage synchroniser with single-cycle rise/fall strobes.
// Strobes stay quiet until the pipeline holds real samples after reset.
module sync_edge_detect #(
    parameter int SYNC_STAGES = link_pkg::DEFAULT_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;
    logic [SYNC_STAGES:0]   fill_q, fill_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        dly_d  = sync_q[SYNC_STAGES-1];
        fill_d = {fill_q[SYNC_STAGES-1:0], 1'b1};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, giving a true shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
            fill_q <= '0;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
            fill_q <= fill_d;
        end
    end

    // A level already high at reset release must not look like an edge.
    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = fill_q[SYNC_STAGES] &  sync_q[SYNC_STAGES-1] & ~dly_q;
    assign fall     = fill_q[SYNC_STAGES] & ~sync_q[SYNC_STAGES-1] &  dly_q;

endmodule

// File: rtl/spi_link_receiver.sv
// Receive end of the inter-node serial link: oversampled SPI slave that
// deserialises MSB-first words into a holding register for the receiver queue.
module spi_link_receiver
    import link_pkg::*;
#(
    parameter int WORD_W      = DEFAULT_WORD_W,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_link_receiver_if.slave link
);

    localparam int CNT_W = $clog2(WORD_W) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_SHIFT   = SHIFT;
    localparam logic [1:0] ST_WAIT_CS = WAIT_CS;

    logic sclk_rise, sclk_sync_unused, sclk_fall_unused;
    logic cs_sync, cs_rise, cs_fall;
    logic sdi_sync, sdi_rise_unused, sdi_fall_unused;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .din(link.sclk_in),
        .sync_out(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .din(link.cs_in),
        .sync_out(cs_sync), .rise(cs_rise), .fall(cs_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sdi_sync (
        .clk(clk), .rst_n(rst_n), .din(link.sdi_in),
        .sync_out(sdi_sync), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
    );

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;
    logic              frame_q, frame_d;
    logic              xfer, overrun_set, frame_set, last_edge;

    // NOTE: every signal gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        xfer        = 1'b0;
        frame_set   = 1'b0;
        last_edge   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                bit_cnt_d = '0;
                if (cs_rise) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bit_cnt_q == CNT_FULL) begin
                    xfer    = 1'b1;
                    state_d = ST_WAIT_CS;
                end else begin
                    last_edge = sclk_rise && (bit_cnt_q == CNT_LAST);
                    if (sclk_rise) begin
                        shift_d   = {shift_q[WORD_W-2:0], sdi_sync};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                    // Select dropping on the final edge still completes the word.
                    if (cs_fall && !last_edge) begin
                        frame_set = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_WAIT_CS: begin
                // Level test also covers a select that fell on the final edge.
                if (!cs_sync) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        word_d      = word_q;
        valid_d     = valid_q;
        overrun_set = 1'b0;

        if (xfer) begin
            if (!valid_q || link.word_ack) begin
                word_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_set = 1'b1;
            end
        end else if (link.word_ack) begin
            valid_d = 1'b0;
        end

        overrun_d = overrun_set | (overrun_q & ~link.clear_err);
        frame_d   = frame_set   | (frame_q   & ~link.clear_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            frame_q   <= frame_d;
        end
    end

    assign link.word_out    = word_q;
    assign link.word_valid  = valid_q;
    assign link.overrun_err = overrun_q;
    assign link.frame_err   = frame_q;
    assign link.busy        = (state_q == ST_SHIFT) || (state_q == ST_WAIT_CS);

endmodule

// File: doc/spi_link_receiver.md
Name: spi_link_receiver

Overview:
- Slave (receive) end of the inter-node serial link that the node's SPI master drives.
- Oversamples the incoming link clock, select and data in the node's system clock domain and deserialises 32-bit instruction words MSB-first.
- Each completed word is presented to the node's receiver queue as a word plus a level-valid "check" flag, held until acknowledged.
- One instance per inbound port (left, right, self).

Parameters:
- WORD_W, 32, bits per frame / width of word_out.
- SYNC_STAGES, 2, synchroniser flops on sclk_in, cs_in and sdi_in (minimum 2).

Ports:
- clk  input  1  system clock; sclk_in frequency must be ≤ clk/4.
- rst_n  input  1  asynchronous active-low reset.
- sclk_in  input  1  link clock from the remote master; data is sampled on its rising edge.
- cs_in  input  1  link select, active-high; frame is valid while high.
- sdi_in  input  1  serial data, MSB first.
- word_ack  input  1  receiver queue consumed word_out; single-cycle pulse.
- clear_err  input  1  clears the sticky error flags.
- word_out  output  WORD_W  last completed word (holding register).
- word_valid  output  1  level; high while word_out holds an unconsumed word (drives the queue's check input).
- overrun_err  output  1  sticky; a word completed while the holding register was full.
- frame_err  output  1  sticky; cs_in dropped mid-word.
- busy  output  1  high in states SHIFT and WAIT_CS.

Behaviour:
- Reset (async assert, sync release): all outputs 0, shift_reg = 0, bit_cnt = 0, state IDLE, synchronisers = 0.
- Synchronisers:
  - All three inputs pass through SYNC_STAGES flops.
  - Edge detect compares the synchronised value with a one-cycle-delayed copy.
  - sclk_rise and cs_rise/cs_fall are single-cycle strobes.
- Counter and shift register: bit_cnt is clog2(WORD_W)+1 bits wide. shift_reg is separate from the holding register, so the next frame can shift while word_out is pending.
- FSM:
  - IDLE: bit_cnt = 0. cs_rise → SHIFT. sclk edges are ignored.
  - SHIFT, on sclk_rise: shift_reg ← {shift_reg[WORD_W-2:0], sdi_sync}; bit_cnt++.
  - SHIFT, when bit_cnt reaches WORD_W: go to WAIT_CS and, in the same cycle, perform the holding-register transfer.
  - SHIFT, on cs_fall with bit_cnt < WORD_W: frame_err ← 1, discard the partial word → IDLE. A cs_fall coincident with the final sclk_rise counts as complete.
  - WAIT_CS: further sclk_rise edges are ignored (no shift, no error). cs_fall → IDLE.
- Holding-register transfer:
  - word_valid = 0: word_out ← shift_reg and word_valid ← 1.
  - word_valid = 1 and word_ack in the same cycle: new word loaded, word_valid stays 1, no error.
  - word_valid = 1 and no ack: new word dropped, word_out unchanged, overrun_err ← 1.
- Ack handling:
  - word_ack with word_valid = 1 and no transfer clears word_valid next clk.
  - word_ack with word_valid = 0 is ignored.
- Error flags: clear_err clears both flags. If clear_err coincides with a new error, the set wins.
- Latency: word_valid rises SYNC_STAGES+2 clk edges after the 32nd sclk rising edge is first sampled at the pin.
- Back-to-back frames: cs_in must stay low for ≥ SYNC_STAGES+1 clk cycles between frames. A shorter gap may be missed; there is no error for this.
- Reset mid-frame: partial word lost, state IDLE. A frame already in progress at reset release is ignored until the next cs_rise.

Decomposition:
- Shared package (link_pkg):
  - WORD_W default.
  - Enum for state: IDLE, SHIFT, WAIT_CS.
  - Common link constants also used by the master side (MSB-first flag, min clk:sclk ratio = 4).
- One natural sub-module: sync_edge_detect. It is a SYNC_STAGES synchroniser plus rise/fall strobes, instanced three times (sclk, cs, sdi; the sdi instance leaves its strobes unused).

Test Plan:
- Basic frame: reset, send 0xA5C3_0F81 at clk/8 with no ack → word_valid rises SYNC_STAGES+2 clks after the 32nd edge, word_out = 0xA5C30F81, no error flags.
- Ack handshake: pulse word_ack while valid → word_valid 0 next clk. A second frame 0x0000_0001 then gives word_out = 1 and valid = 1.
- Overrun: send 0x11111111, no ack, send 0x22222222 → word_out stays 0x11111111, overrun_err = 1. Pulsing clear_err → overrun_err = 0.
- Ack coincident with completion: time word_ack to the transfer cycle of 0x33333333 while 0x22222222 is held → word_out = 0x33333333, valid stays 1, overrun_err = 0.
- Short frame: drop cs_in after 17 bits → frame_err = 1, word_valid unchanged. A following full frame 0xDEADBEEF is received correctly.
- Extra clocks and reset: 40 sclk edges in one frame → word = first 32 bits, no error. Assert rst_n low mid-frame → all outputs 0 immediately.
